// File: rtl/wide_alu_sequencer_pkg.sv
// Shared types for the wide ALU sequencer: ALU op codes, wide opcodes, FSM states.
// Package name is 'definitions'; imported by the interface, sequencer and bench.
package definitions;

    typedef enum logic [7:0] {
        ADD = 8'h00,
        SUB = 8'h01,
        LSL = 8'h02,
        LSR = 8'h03,
        OR  = 8'h04
    } op_code_t;

    typedef enum logic [1:0] {
        W_ADD16 = 2'd0,
        W_SUB16 = 2'd1,
        W_LSL16 = 2'd2,
        W_LSR16 = 2'd3
    } wide_op_t;

    typedef enum logic [2:0] {
        IDLE,
        STEP_A,
        STEP_B,
        FIX,
        DONE
    } wseq_state_t;

endpackage

// File: rtl/wide_alu_sequencer_if.sv
// Control-side bundle between the core control unit (master) and the sequencer (slave).
// Ports: start_i/wop_i/a_i/b_i request; busy_o/done_o/result_o/carry_o/zero_o/neg_o status.
interface wide_alu_sequencer_if;
    logic                 start_i;
    definitions::wide_op_t wop_i;
    logic [15:0]          a_i;
    logic [15:0]          b_i;
    logic                 busy_o;
    logic                 done_o;
    logic [15:0]          result_o;
    logic                 carry_o;
    logic                 zero_o;
    logic                 neg_o;

    modport master (
        output start_i, wop_i, a_i, b_i,
        input  busy_o, done_o, result_o, carry_o, zero_o, neg_o
    );

    modport slave (
        input  start_i, wop_i, a_i, b_i,
        output busy_o, done_o, result_o, carry_o, zero_o, neg_o
    );
endinterface

// File: rtl/wide_alu_sequencer_carry.sv
// wide_seq_carry: combinational inter-byte flag and final carry/borrow/shift-out logic.
// Ports: wop_i, a_i, b_i, res_i (ALU result), hi_i, c_i, x_i -> x_next_o, c_base_o, c_final_o.
module wide_seq_carry
    import definitions::*;
(
    input  wide_op_t    wop_i,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic [7:0]  res_i,
    input  logic [7:0]  hi_i,
    input  logic        c_i,
    input  logic        x_i,
    output logic        x_next_o,
    output logic        c_base_o,
    output logic        c_final_o
);
    logic fix_c;

    // res_i is the low-byte result in STEP_A, the high-byte result in STEP_B,
    // and the fixed-up byte in FIX; each output is consumed only in its step.
    always_comb begin
        x_next_o = 1'b0;
        c_base_o = 1'b0;
        fix_c    = 1'b0;
        unique case (wop_i)
            W_ADD16: begin
                x_next_o = res_i < a_i[7:0];
                c_base_o = res_i < a_i[15:8];
                fix_c    = res_i == 8'h00;
            end
            W_SUB16: begin
                x_next_o = a_i[7:0] < b_i[7:0];
                c_base_o = a_i[15:8] < b_i[15:8];
                fix_c    = hi_i == 8'h00;
            end
            W_LSL16: begin
                x_next_o = a_i[7];
                c_base_o = a_i[15];
            end
            W_LSR16: begin
                x_next_o = a_i[8];
                c_base_o = a_i[0];
            end
        endcase
        // A padding FIX with x=0 must never contribute a carry.
        c_final_o = c_i | (x_i & fix_c);
    end
endmodule

// File: rtl/wide_alu_sequencer.sv
// 16-bit ADD/SUB/LSL/LSR sequenced as byte steps through an external 8-bit ALU.
// Ports: clk_i, reset_i, bus (slave), alu_rs_o/alu_rt_o/alu_op_o, alu_result_i. Option: WIDE_SEQ_CONST_LAT_EN.
module wide_alu_sequencer
    import definitions::*;
(
    input  logic                       clk_i,
    input  logic                       reset_i,
    wide_alu_sequencer_if.slave        bus,
    output logic [7:0]                 alu_rs_o,
    output logic [7:0]                 alu_rt_o,
    output logic [8:0]                 alu_op_o,
    input  logic [7:0]                 alu_result_i
);
    wseq_state_t state_q, state_d;
    wide_op_t    wop_q;
    logic [15:0] a_q, b_q;
    logic [7:0]  lo_q, hi_q;
    logic        x_q, c_q;
    logic [15:0] result_q;
    logic        carry_q, zero_q, neg_q;

    op_code_t    op;
    logic [15:0] res_next;
    logic        carry_next;
    logic        x_next, c_base, c_final;
    logic        is_lsr;

    assign is_lsr = wop_q == W_LSR16;

    wide_seq_carry u_carry (
        .wop_i     (wop_q),
        .a_i       (a_q),
        .b_i       (b_q),
        .res_i     (alu_result_i),
        .hi_i      (hi_q),
        .c_i       (c_q),
        .x_i       (x_q),
        .x_next_o  (x_next),
        .c_base_o  (c_base),
        .c_final_o (c_final)
    );

    always_comb begin
        state_d    = state_q;
        op         = ADD;
        alu_rs_o   = 8'h00;
        alu_rt_o   = 8'h00;
        res_next   = {hi_q, lo_q};
        carry_next = c_base;
        unique case (state_q)
            IDLE: begin
                if (bus.start_i) state_d = STEP_A;
            end
            STEP_A: begin
                state_d = STEP_B;
                unique case (wop_q)
                    W_ADD16: begin op = ADD; alu_rs_o = a_q[7:0];  alu_rt_o = b_q[7:0]; end
                    W_SUB16: begin op = SUB; alu_rs_o = a_q[7:0];  alu_rt_o = b_q[7:0]; end
                    W_LSL16: begin op = LSL; alu_rs_o = a_q[7:0];  alu_rt_o = 8'h01;    end
                    W_LSR16: begin op = LSR; alu_rs_o = a_q[15:8]; alu_rt_o = 8'h01;    end
                endcase
            end
            STEP_B: begin
`ifdef WIDE_SEQ_CONST_LAT_EN
                state_d = FIX;
`else
                state_d = x_q ? FIX : DONE;
`endif
                unique case (wop_q)
                    W_ADD16: begin op = ADD; alu_rs_o = a_q[15:8]; alu_rt_o = b_q[15:8]; end
                    W_SUB16: begin op = SUB; alu_rs_o = a_q[15:8]; alu_rt_o = b_q[15:8]; end
                    W_LSL16: begin op = LSL; alu_rs_o = a_q[15:8]; alu_rt_o = 8'h01;     end
                    W_LSR16: begin op = LSR; alu_rs_o = a_q[7:0];  alu_rt_o = 8'h01;     end
                endcase
                res_next   = is_lsr ? {hi_q, alu_result_i} : {alu_result_i, lo_q};
                carry_next = c_base;
            end
            FIX: begin
                state_d = DONE;
                // x_q doubles as the fix operand so a padding FIX is a no-op.
                unique case (wop_q)
                    W_ADD16: begin op = ADD; alu_rs_o = hi_q; alu_rt_o = {7'b0, x_q}; end
                    W_SUB16: begin op = SUB; alu_rs_o = hi_q; alu_rt_o = {7'b0, x_q}; end
                    W_LSL16: begin op = OR;  alu_rs_o = hi_q; alu_rt_o = {7'b0, x_q}; end
                    W_LSR16: begin op = OR;  alu_rs_o = lo_q; alu_rt_o = {x_q, 7'b0}; end
                endcase
                res_next   = is_lsr ? {hi_q, alu_result_i} : {alu_result_i, lo_q};
                carry_next = c_final;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        alu_op_o = {op, 1'b0};
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            wop_q    <= W_ADD16;
            a_q      <= '0;
            b_q      <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            x_q      <= 1'b0;
            c_q      <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        wop_q <= bus.wop_i;
                        a_q   <= bus.a_i;
                        b_q   <= bus.b_i;
                    end
                end
                STEP_A: begin
                    if (is_lsr) hi_q <= alu_result_i;
                    else        lo_q <= alu_result_i;
                    x_q <= x_next;
                end
                STEP_B: begin
                    {hi_q, lo_q} <= res_next;
                    c_q          <= c_base;
                end
                FIX: begin
                    {hi_q, lo_q} <= res_next;
                end
                default: ;
            endcase
            if (state_d == DONE && state_q != DONE) begin
                result_q <= res_next;
                carry_q  <= carry_next;
                zero_q   <= res_next == 16'h0000;
                neg_q    <= res_next[15];
            end
        end
    end

    assign bus.busy_o   = state_q != IDLE;
    assign bus.done_o   = state_q == DONE;
    assign bus.result_o = result_q;
    assign bus.carry_o  = carry_q;
    assign bus.zero_o   = zero_q;
    assign bus.neg_o    = neg_q;
endmodule

// File: tb/tb_wide_alu_sequencer.sv
// Bench for wide_alu_sequencer: directed vector table plus start-hold and mid-op reset sequences.
// Includes a behavioural 8-bit ALU; honours WIDE_SEQ_CONST_LAT_EN for latency expectations.
module tb_wide_alu_sequencer;
    import definitions::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rs, rt, ares;
    logic [8:0] aop;
    int         total = 0;
    int         bad   = 0;

    wide_alu_sequencer_if bus ();

    always #5 clk = ~clk;

    wide_alu_sequencer dut (
        .clk_i        (clk),
        .reset_i      (rst),
        .bus          (bus),
        .alu_rs_o     (rs),
        .alu_rt_o     (rt),
        .alu_op_o     (aop),
        .alu_result_i (ares)
    );

    always_comb begin
        ares = 8'h00;
        case (aop[8:1])
            ADD:     ares = rs + rt;
            SUB:     ares = rs - rt;
            LSL:     ares = rs << rt[2:0];
            LSR:     ares = rs >> rt[2:0];
            OR:      ares = rs | rt;
            default: ares = 8'h00;
        endcase
    end

    typedef struct {
        wide_op_t    wop;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        c;
        int          lat;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        @(negedge clk);
        for (int g = 0; g < 12 && bus.busy_o; g++) @(negedge clk);
    endtask

    // Issues one request and returns the cycle (1 = STEP_A) in which done_o shows.
    task automatic run(input wide_op_t w, input logic [15:0] a, input logic [15:0] b,
                       output int lat);
        wait_idle();
        bus.wop_i   = w;
        bus.a_i     = a;
        bus.b_i     = b;
        bus.start_i = 1'b1;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            if (bus.done_o) begin
                lat = k;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int lat, exp_lat, dones;

        vecs[0]  = '{W_ADD16, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 4};
        vecs[1]  = '{W_ADD16, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 4};
        vecs[2]  = '{W_ADD16, 16'h1234, 16'h0101, 16'h1335, 1'b0, 3};
        vecs[3]  = '{W_SUB16, 16'h0100, 16'h0001, 16'h00FF, 1'b0, 4};
        vecs[4]  = '{W_SUB16, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 4};
        vecs[5]  = '{W_LSL16, 16'h80C0, 16'h0000, 16'h0180, 1'b1, 4};
        vecs[6]  = '{W_LSR16, 16'h0101, 16'h0000, 16'h0080, 1'b1, 4};
        vecs[7]  = '{W_ADD16, 16'h8000, 16'h8000, 16'h0000, 1'b1, 3};
        vecs[8]  = '{W_SUB16, 16'h5678, 16'h1234, 16'h4444, 1'b0, 3};
        vecs[9]  = '{W_LSR16, 16'h8001, 16'h0000, 16'h4000, 1'b1, 3};
        vecs[10] = '{W_LSL16, 16'h4001, 16'hFFFF, 16'h8002, 1'b0, 3};

        rst         = 1'b1;
        bus.start_i = 1'b0;
        bus.wop_i   = W_ADD16;
        bus.a_i     = '0;
        bus.b_i     = '0;
        #12;
        chk("rst_busy",   32'(bus.busy_o),   32'h0);
        chk("rst_done",   32'(bus.done_o),   32'h0);
        chk("rst_result", 32'(bus.result_o), 32'h0);
        chk("rst_flags",  32'({bus.carry_o, bus.zero_o, bus.neg_o}), 32'h0);
        chk("rst_aluop",  32'(aop),          32'({ADD, 1'b0}));
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
`ifdef WIDE_SEQ_CONST_LAT_EN
            exp_lat = 4;
`else
            exp_lat = vecs[i].lat;
`endif
            run(vecs[i].wop, vecs[i].a, vecs[i].b, lat);
            chk($sformatf("v%0d_lat", i),    32'(lat),          32'(exp_lat));
            chk($sformatf("v%0d_result", i), 32'(bus.result_o), 32'(vecs[i].res));
            chk($sformatf("v%0d_carry", i),  32'(bus.carry_o),  32'(vecs[i].c));
            chk($sformatf("v%0d_zero", i),   32'(bus.zero_o),   32'(vecs[i].res == 16'h0));
            chk($sformatf("v%0d_neg", i),    32'(bus.neg_o),    32'(vecs[i].res[15]));
        end

        // LSR routes the high byte first.
        wait_idle();
        bus.wop_i   = W_LSR16;
        bus.a_i     = 16'h0101;
        bus.b_i     = 16'h0000;
        bus.start_i = 1'b1;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        chk("lsr_stepa_rs", 32'(rs),  32'h01);
        chk("lsr_stepa_rt", 32'(rt),  32'h01);
        chk("lsr_stepa_op", 32'(aop), 32'({LSR, 1'b0}));
        chk("lsr_stepa_busy", 32'(bus.busy_o), 32'h1);

        // start_i held high for ten cycles: exactly two accepts/done pulses.
        wait_idle();
        bus.wop_i   = W_ADD16;
        bus.a_i     = 16'h1234;
        bus.b_i     = 16'h0101;
        bus.start_i = 1'b1;
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (bus.done_o) dones++;
        end
        bus.start_i = 1'b0;
        chk("hold_dones", 32'(dones), 32'h2);
        wait_idle();
        chk("hold_result", 32'(bus.result_o), 32'h1335);

        // Reset during STEP_B aborts without a done pulse.
        bus.wop_i   = W_ADD16;
        bus.a_i     = 16'h00FF;
        bus.b_i     = 16'h0001;
        bus.start_i = 1'b1;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy_pre", 32'(bus.busy_o), 32'h1);
        rst = 1'b1;
        #1;
        chk("abort_busy",   32'(bus.busy_o),   32'h0);
        chk("abort_result", 32'(bus.result_o), 32'h0);
        chk("abort_done",   32'(bus.done_o),   32'h0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (bus.done_o || bus.busy_o) dones++;
        end
        chk("abort_quiet", 32'(dones), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wide_alu_sequencer.md
# wide_alu_sequencer

Multi-cycle controller that performs 16-bit ADD, SUB, LSL-by-1 and LSR-by-1 by sequencing byte-wide operations through the 8-bit ALU. The controller owns operand routing, inter-byte carry/borrow tracking and flag generation. It sits between the core's control unit and the `alu` instance. While a wide operation is in flight, the sequencer drives the ALU operand and opcode inputs. ALU `carry_o` is never consumed; all inter-byte carry is derived inside the sequencer.

## Interface
- No parameters.
- `clk_i` in 1: clock, rising edge.
- `reset_i` in 1: asynchronous, active-high reset.
- `start_i` in 1: request a wide operation; sampled only in IDLE.
- `wop_i` in 2: wide opcode, `wide_op_t` (W_ADD16=0, W_SUB16=1, W_LSL16=2, W_LSR16=3).
- `a_i` in 16: operand A; captured at accept.
- `b_i` in 16: operand B; captured at accept; ignored for shifts.
- `alu_rs_o` out 8: to ALU `rs_i`.
- `alu_rt_o` out 8: to ALU `rt_i`.
- `alu_op_o` out 9: to ALU `op_i`, always `{op_code, 1'b0}`.
- `alu_result_i` in 8: from ALU `result_o`.
- `busy_o` out 1: high in every state except IDLE.
- `done_o` out 1: one-cycle pulse in DONE.
- `result_o` out 16: registered result; held until the next accept.
- `carry_o` out 1: carry/borrow/shifted-out bit.
- `zero_o` out 1: result_o == 0.
- `neg_o` out 1: result_o[15].

## Operation
- FSM states: IDLE, STEP_A, STEP_B, FIX, DONE.
- IDLE:
  - `start_i`=1 latches `wop_i`, `a_i`, `b_i` and moves to STEP_A.
  - Outputs `alu_op_o={ADD,0}`, `rs`=`rt`=0.
- STEP_A (result captured into `lo_q`, or `hi_q` for LSR):
  - ADD16: ADD a_lo,b_lo. SUB16: SUB a_lo,b_lo. LSL16: LSL a_lo,1. LSR16: LSR a_hi,1.
- STEP_B (result captured into the other byte register):
  - ADD16: ADD a_hi,b_hi. SUB16: SUB a_hi,b_hi. LSL16: LSL a_hi,1. LSR16: LSR a_lo,1.
- Inter-byte flag `x_q`, computed at the end of STEP_A in unsigned 8-bit arithmetic:
  - ADD16: `lo_res < a_lo`. SUB16: `a_lo < b_lo`. LSL16: `a_lo[7]`. LSR16: `a_hi[0]`.
- STEP_B goes to FIX if `x_q`=1, otherwise to DONE.
- FIX:
  - ADD16: ADD hi_q,1. SUB16: SUB hi_q,1. LSL16: OR hi_q,8'h01. LSR16: OR lo_q,8'h80.
  - The result overwrites the same byte register.
- `carry_o`:
  - ADD16: `(hi_res < a_hi) | (FIX taken & fix_res==0)`.
  - SUB16: `(a_hi < b_hi) | (FIX taken & hi_q==0)`.
  - LSL16: `a_hi[7]`. LSR16: `a_lo[0]`.
- DONE:
  - `result_o` = {hi_q, lo_q}, and flags are registered on entry.
  - `done_o`=1; `start_i` is ignored; next state is IDLE.
- `start_i` during any non-IDLE state is ignored and not queued.

## Timing
- Reset (asynchronous): state IDLE; `busy_o`, `done_o`, `result_o`, `carry_o`, `zero_o`, `neg_o` = 0; `alu_op_o={ADD,0}`; internal registers = 0.
- Accept edge E0. STEP_A occupies cycle 1, STEP_B cycle 2, FIX (if taken) cycle 3.
- `done_o` is high in cycle 3 without FIX, cycle 4 with FIX. The earliest next accept is at the end of the DONE cycle plus one (IDLE).
- The ALU path is combinational. Each step's `alu_result_i` is sampled at the step's closing edge.
- Reset mid-operation aborts immediately. No `done_o` is produced, and `result_o` clears to 0.
- `result_o` and flags change only on DONE entry and on reset.

## Configuration
- `WIDE_SEQ_CONST_LAT_EN` defined:
  - FIX is always executed, using operand 0 (ADD/SUB) or 8'h00 (OR) when `x_q`=0.
  - `done_o` is always in cycle 4, and results are unchanged.
- Undefined: variable latency, 3 or 4 cycles, as above.

## Structure
- `wide_op_t` and `wseq_state_t` enums belong in `definitions`.
- The ALU `op_code` values used (ADD, SUB, LSL, LSR, OR) come from the existing `definitions` enum; no new ALU opcodes.
- One natural sub-module: `wide_seq_carry`, combinational. It computes `x_q` next-value and the final `carry_o` from the operation, operand bytes and step results.
- The FSM, operand muxing and result registers stay in the top module.

## Test plan
- ADD16 0x00FF+0x0001 → result 0x0100, FIX taken, `done_o` at cycle 4, carry 0, zero 0, neg 0.
- ADD16 0xFFFF+0x0001 → result 0x0000, carry 1, zero 1. ADD16 0x1234+0x0101 → 0x1335, no FIX, `done_o` at cycle 3.
- SUB16 0x0100−0x0001 → 0x00FF, carry 0. SUB16 0x0000−0x0001 → 0xFFFF, carry 1, neg 1.
- LSL16 0x80C0 → 0x0180, carry 1. LSR16 0x0101 → 0x0080, carry 1, with STEP_A ALU inputs rs=0x01, op LSR.
- `start_i` held high through an operation → exactly one `done_o` per accept, and a new accept only from IDLE. `reset_i` asserted in STEP_B → `busy_o`=0 and `result_o`=0 immediately, no `done_o`.
- With `WIDE_SEQ_CONST_LAT_EN`, ADD16 0x1234+0x0101 → 0x1335 with `done_o` at cycle 4.
